rv32_mod_dmem_responder: RTL
============================

RV32_MOD_DMEM_RESPONDER -- requirements
Module: rv32_mod_dmem_responder

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 32'h0001_0000, byte address of word 0.
REQ-002 SHALL have parameter: DEPTH_WORDS, 256, number of 32-bit words (power of two, >=2).
REQ-003 SHALL have parameter: WAIT_STATES, 0, extra cycles inserted before each response (0..15).
REQ-004 SHALL have port: clk  in  1  clock, rising edge.
REQ-005 SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: dext_req  in  1  request strobe, one-cycle pulse per transaction.
REQ-007 SHALL have port: dext_wr  in  1  1=write, 0=read; valid with dext_req.
REQ-008 SHALL have port: dext_be  in  4  byte enables; valid with dext_req.
REQ-009 SHALL have port: dext_addr  in  32  byte address; valid with dext_req.
REQ-010 SHALL have port: dext_do  in  32  write data from initiator; valid with dext_req.
REQ-011 SHALL have port: dext_di  out  32  read data to initiator; valid only while dext_ack.
REQ-012 SHALL have port: dext_ack  out  1  success response, one-cycle pulse.
REQ-013 SHALL have port: dext_err  out  1  error response, one-cycle pulse.
REQ-014 SHALL have port: overrun  out  1  sticky flag: a request was dropped.

Function
REQ-015 SHALL sample request fields only in cycles where dext_req=1.
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; dext_ack/dext_err asserted only in RESP, registered.
REQ-017 IDLE + dext_req: capture request; go WAIT with counter=WAIT_STATES-1, or RESP directly if WAIT_STATES=0.
REQ-018 WAIT: decrement counter each cycle; go RESP when counter=0.
REQ-019 SHALL respond exactly 1+WAIT_STATES cycles after the request cycle.
REQ-020 RESP lasts one cycle; then the next transaction starts (pending entry first, else a same-cycle dext_req), else IDLE.
REQ-021 Next transaction started from RESP SHALL follow REQ-017 timing, giving back-to-back responses when WAIT_STATES=0.
REQ-022 SHALL hold one pending entry; dext_req in WAIT, or in RESP while pending full, is stored there if free.
REQ-023 dext_req arriving while pending full and not consumed that cycle SHALL be dropped and set overrun; no response for it.
REQ-024 Error if addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), addr[1:0]!=0, or be=0; error responds via dext_err with same timing as ack.
REQ-025 dext_ack and dext_err SHALL never be asserted together.
REQ-026 Write: on the edge entering RESP, update only bytes with be[i]=1; other bytes unchanged.
REQ-027 Read: dext_di = memory word, captured on the edge entering RESP; dext_di=0 outside ack cycles, on error, and on writes.
REQ-028 A read immediately following a write to the same word SHALL return the written data.
REQ-029 Erroring writes SHALL not modify memory.
REQ-030 Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; no wrap-around aliasing.

Reset
REQ-031 Reset SHALL force IDLE, clear pending entry, counter=0, dext_ack=0, dext_err=0, dext_di=0, overrun=0.
REQ-032 Reset mid-transaction SHALL abort it with no response; a write not yet in RESP leaves memory unchanged.
REQ-033 Memory contents SHALL not be reset.

Structure
REQ-034 Shared package rv32_dbus_pkg SHALL hold the FSM state enum and the request struct (wr, be, addr, wdata).
REQ-035 Storage SHALL be sub-module rv32_mod_byte_ram (word RAM, per-byte write enables, synchronous read).

Verification
REQ-036 WAIT_STATES=0: write 0xDEADBEEF be=1111 @0x00010010, then read it -> ack 1 cycle after each req; di=0xDEADBEEF.
REQ-037 Partial write be=0100 data 0x00AA0000 @0x00010010, read -> di=0xDEAABEEF.
REQ-038 WAIT_STATES=2: read @0x00010000 -> ack exactly 3 cycles after req; req in cycles 0,1 -> acks in cycles 3,6.
REQ-039 Reads @0x00020000, @0x00010002, be=0000 -> dext_err pulse each, di=0, ack=0; erroring write leaves memory unchanged.
REQ-040 WAIT_STATES=3: req in cycles 0,1,2 -> third dropped, overrun=1 stays set, exactly two responses.
REQ-041 Assert reset during WAIT of a write -> no ack/err; subsequent read of that word returns old value.

Source files
------------

// File: rtl/rv32_dbus_pkg.sv
// Shared data-bus types: responder FSM states and the captured request payload.
package rv32_dbus_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dbus_state_e;

   typedef struct packed {
      logic        wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dbus_req_t;

endpackage

// File: rtl/rv32_mod_byte_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
module rv32_mod_byte_ram #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          re,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   // Read data is only non-zero in the cycle after a read strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata <= '0;
      else       rdata <= re ? mem[addr] : '0;
   end

endmodule

// File: rtl/rv32_mod_dmem_responder.sv
// Data-memory bus responder: fixed-latency ack/err with a one-deep pending request slot.
module rv32_mod_dmem_responder
   import rv32_dbus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dext_req,
   input  logic        dext_wr,
   input  logic [3:0]  dext_be,
   input  logic [31:0] dext_addr,
   input  logic [31:0] dext_do,
   output logic [31:0] dext_di,
   output logic        dext_ack,
   output logic        dext_err,
   output logic        overrun
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
   localparam logic [CNT_W-1:0] WAIT_INIT =
      (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

   dbus_state_e      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   dbus_req_t        cur, cur_n;
   dbus_req_t        pend, pend_n;
   logic             pend_v, pend_v_n;
   logic             overrun_n;
   dbus_req_t        in_req;
   dbus_req_t        start_req_c;
   logic             start_c;
   logic [32:0]      off_c;
   logic             err_c;
   logic             enter_c;
   logic             ram_re;
   logic [3:0]       ram_we;

   assign in_req = '{wr: dext_wr, be: dext_be, addr: dext_addr, wdata: dext_do};

   // Next-state logic; a started transaction always goes through the same WAIT/RESP timing.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cur_n       = cur;
      pend_n      = pend;
      pend_v_n    = pend_v;
      overrun_n   = overrun;
      start_c     = 1'b0;
      start_req_c = in_req;
      case (state)
         IDLE: begin
            if (dext_req) start_c = 1'b1;
         end
         WAIT: begin
            if (cnt == '0) state_n = RESP;
            else           cnt_n   = cnt - CNT_W'(1);
            if (dext_req) begin
               if (!pend_v) begin
                  pend_n   = in_req;
                  pend_v_n = 1'b1;
               end else begin
                  overrun_n = 1'b1;
               end
            end
         end
         RESP: begin
            if (pend_v) begin
               // Pending slot drains this cycle, so a new request can refill it.
               start_c     = 1'b1;
               start_req_c = pend;
               pend_v_n    = dext_req;
               if (dext_req) pend_n = in_req;
            end else if (dext_req) begin
               start_c = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (start_c) begin
         cur_n   = start_req_c;
         cnt_n   = WAIT_INIT;
         state_n = (WAIT_STATES == 0) ? RESP : WAIT;
      end
   end

   // Decode of the transaction about to respond; out-of-range below base wraps to a huge offset.
   always_comb begin
      off_c   = {1'b0, cur_n.addr} - {1'b0, BASE_ADDR};
      err_c   = (off_c >= SPAN) || (cur_n.addr[1:0] != 2'b00) || (cur_n.be == 4'b0000);
      enter_c = (state_n == RESP);
      ram_re  = enter_c && !err_c && !cur_n.wr;
      ram_we  = {4{enter_c && !err_c && cur_n.wr && !reset}} & cur_n.be;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cur      <= '0;
         pend     <= '0;
         pend_v   <= 1'b0;
         overrun  <= 1'b0;
         dext_ack <= 1'b0;
         dext_err <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         cur      <= cur_n;
         pend     <= pend_n;
         pend_v   <= pend_v_n;
         overrun  <= overrun_n;
         dext_ack <= enter_c && !err_c;
         dext_err <= enter_c && err_c;
      end
   end

   rv32_mod_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .re    (ram_re),
      .we    (ram_we),
      .addr  (off_c[AW+1:2]),
      .wdata (cur_n.wdata),
      .rdata (dext_di)
   );

endmodule
